// File: rtl/cpu_run_pkg.sv
// Shared encodings for the cpu_run_ctrl run/halt sequencer: FSM states,
// halt-cause codes and the ebreak encoding.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_REQ     = 3'd1,
        CAUSE_EBREAK  = 3'd2,
        CAUSE_ILLEGAL = 3'd3,
        CAUSE_BKPT    = 3'd4,
        CAUSE_LIMIT   = 3'd5,
        CAUSE_STEP    = 3'd6
    } halt_cause_t;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    // Sticky causes cannot be resumed from; only clr or reset leaves them.
    function automatic logic cause_is_sticky(input halt_cause_t c);
        return (c == CAUSE_LIMIT) || (c == CAUSE_ILLEGAL) || (c == CAUSE_EBREAK);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_halt_detect.sv
// Combinational halt check on the instruction currently presented by the
// core; reports whether to halt and the highest-priority cause.
module halt_detect
    import cpu_run_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 250
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [31:0]      instr,
    input  logic [CYC_W-1:0] cycle_cnt,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_skip,
    input  logic             halt_req,
    input  logic             run_qual,
    output logic             hc,
    output halt_cause_t      cause
);

    localparam logic [CYC_W-1:0] LIMIT_CNT = CYC_W'(MAX_CYCLES);

    always_comb begin
        // NOTE: every output gets a default before the priority chain so no latch is inferred.
        cause = CAUSE_NONE;
        if ((instr[1:0] != 2'b11) || (instr == 32'd0)) begin
            cause = CAUSE_ILLEGAL;
        end else if (instr == EBREAK_INSN) begin
            cause = CAUSE_EBREAK;
        end else if (cycle_cnt == LIMIT_CNT) begin
            cause = CAUSE_LIMIT;
        end else if (bp_en && (pc == bp_addr) && !bp_skip) begin
            cause = CAUSE_BKPT;
        end else if (halt_req && run_qual) begin
            cause = CAUSE_REQ;
        end
        hc = (cause != CAUSE_NONE);
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the single-cycle core: drives the core clock-enable,
// handles start/step/halt and reports the halt cause and enabled-cycle count.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 250
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic             clr,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic [31:0]      instr,
    output logic             cpu_en,
    output logic             halted,
    output logic             halt_pulse,
    output logic [2:0]       halt_cause,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic [1:0]       state
);

    run_state_t       state_q;
    halt_cause_t      cause_q;
    logic [CYC_W-1:0] cnt_q;
    logic             bp_skip_q;
    logic             halt_entered_q;
    logic             halt_pulse_q;

    logic             hc;
    halt_cause_t      hc_cause;

    halt_detect #(
        .PC_W       (PC_W),
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_halt_detect (
        .pc        (pc),
        .instr     (instr),
        .cycle_cnt (cnt_q),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .bp_skip   (bp_skip_q),
        .halt_req  (halt_req),
        .run_qual  (state_q == ST_RUN),
        .hc        (hc),
        .cause     (hc_cause)
    );

    // Mealy enable: the halting instruction is blocked in the same cycle it appears.
    always_comb begin
        cpu_en = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !hc;
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every read sees pre-edge values.
        if (!rstn || clr) begin
            state_q        <= ST_IDLE;
            cause_q        <= CAUSE_NONE;
            cnt_q          <= '0;
            bp_skip_q      <= 1'b0;
            halt_entered_q <= 1'b0;
            halt_pulse_q   <= 1'b0;
        end else begin
            halt_pulse_q   <= halt_entered_q;
            halt_entered_q <= 1'b0;

            if (cpu_en) begin
                if (cnt_q != {CYC_W{1'b1}}) begin
                    cnt_q <= cnt_q + CYC_W'(1);
                end
                bp_skip_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start || step) begin
                        state_q <= start ? ST_RUN : ST_STEP;
                        cnt_q   <= '0;
                        cause_q <= CAUSE_NONE;
                    end
                end
                ST_RUN: begin
                    if (hc) begin
                        state_q        <= ST_HALT;
                        cause_q        <= hc_cause;
                        halt_entered_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q        <= ST_HALT;
                    cause_q        <= hc ? hc_cause : CAUSE_STEP;
                    halt_entered_q <= 1'b1;
                end
                ST_HALT: begin
                    if ((start || step) && !cause_is_sticky(cause_q)) begin
                        state_q <= start ? ST_RUN : ST_STEP;
                        cause_q <= CAUSE_NONE;
                        // Resuming from a breakpoint must execute that instruction once.
                        if (cause_q == CAUSE_BKPT) begin
                            bp_skip_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign halted     = (state_q == ST_HALT);
    assign halt_pulse = halt_pulse_q;
    assign halt_cause = cause_q;
    assign cycle_cnt  = cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a small core emulator feeds pc/instr, a behavioural
// model predicts every output each cycle, and directed steps pin key values.
module tb_cpu_run_ctrl;

    localparam int MAXC = 250;

    logic        clk = 1'b0;
    logic        rstn, start, step, halt_req, clr, bp_en;
    logic [31:0] bp_addr, pc, instr;
    logic        cpu_en, halted, halt_pulse;
    logic [2:0]  halt_cause;
    logic [15:0] cycle_cnt;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];

    // Model: 0=idle 1=run 2=step 3=halt; causes use the external code values.
    int m_st = 0, m_cause = 0, m_cnt = 0;
    bit m_skip = 0, m_pulse = 0, m_prev_halt = 0;

    cpu_run_ctrl #(.PC_W(32), .CYC_W(16), .MAX_CYCLES(MAXC)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .step       (step),
        .halt_req   (halt_req),
        .clr        (clr),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .instr      (instr),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .halt_pulse (halt_pulse),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_hc();
        if (instr[1:0] != 2'b11 || instr == 32'd0) return 3;
        if (instr == 32'h0010_0073) return 2;
        if (m_cnt == MAXC) return 5;
        if (bp_en && pc == bp_addr && !m_skip) return 4;
        if (halt_req && m_st == 1) return 1;
        return 0;
    endfunction

    function automatic bit model_en();
        return (m_st == 1 || m_st == 2) && model_hc() == 0;
    endfunction

    always @(posedge clk) begin
        if (!rstn || clr) begin
            m_st <= 0; m_cause <= 0; m_cnt <= 0;
            m_skip <= 0; m_pulse <= 0; m_prev_halt <= 0;
        end else begin
            m_pulse     <= (m_st == 3) && !m_prev_halt;
            m_prev_halt <= (m_st == 3);
            if (model_en()) begin
                m_cnt  <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                m_skip <= 0;
            end
            if (m_st == 0 && (start || step)) begin
                m_st <= start ? 1 : 2; m_cnt <= 0; m_cause <= 0;
            end else if (m_st == 1 && model_hc() != 0) begin
                m_st <= 3; m_cause <= model_hc();
            end else if (m_st == 2) begin
                m_st <= 3; m_cause <= (model_hc() != 0) ? model_hc() : 6;
            end else if (m_st == 3 && (start || step) && !(m_cause inside {2, 3, 5})) begin
                m_st <= start ? 1 : 2; m_cause <= 0;
                if (m_cause == 4) m_skip <= 1;
            end
        end
    end

    always @(negedge clk) begin
        check("cpu_en", cpu_en, model_en());
        check("state", state, m_st);
        check("halted", halted, m_st == 3);
        check("halt_pulse", halt_pulse, m_pulse);
        check("halt_cause", halt_cause, m_cause);
        check("cycle_cnt", cycle_cnt, m_cnt);
    end

    // One clock: the emulated core advances pc when enabled; pulses drop after the edge.
    task automatic tick();
        bit adv;
        adv = model_en();
        @(posedge clk);
        #1;
        if (adv) pc = pc + 32'd4;
        instr    = mem[pc[9:2]];
        start    = 1'b0;
        step     = 1'b0;
        halt_req = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en_cnt;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        rstn = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0; clr = 1'b0;
        bp_en = 1'b0; bp_addr = 32'd0; pc = 32'd0; instr = mem[0];

        // Reset state
        tick(); tick(); #1;
        check("rst_state", state, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_cause", halt_cause, 0);
        check("rst_halted", halted, 0);
        check("rst_pulse", halt_pulse, 0);
        rstn = 1'b1;
        tick();

        // Cycle budget: exactly 250 enabled cycles, then sticky LIMIT halt
        start = 1'b1; tick();
        en_cnt = 0;
        for (int i = 0; i < 300 && !halted; i++) begin
            @(negedge clk);
            if (cpu_en) en_cnt++;
            tick();
        end
        #1;
        check("limit_en_cycles", en_cnt, 250);
        check("limit_cause", halt_cause, 5);
        check("limit_cnt", cycle_cnt, 250);
        check("limit_halted", halted, 1);
        start = 1'b1; tick(); #1;
        check("limit_start_ignored", state, 3);
        check("limit_cause_kept", halt_cause, 5);
        step = 1'b1; tick(); #1;
        check("limit_step_ignored", state, 3);

        // ebreak at 0x010
        clr = 1'b1; tick();
        pc = 32'd0; instr = mem[0]; mem[4] = 32'h0010_0073;
        start = 1'b1; tick();
        for (int i = 0; i < 20 && pc != 32'h10; i++) tick();
        #1;
        check("ebreak_pc", pc, 32'h10);
        check("ebreak_blocked", cpu_en, 0);
        tick(); #1;
        check("ebreak_halted", halted, 1);
        check("ebreak_cause", halt_cause, 2);
        check("ebreak_pulse_early", halt_pulse, 0);
        check("ebreak_cnt", cycle_cnt, 4);
        tick(); #1;
        check("ebreak_pulse", halt_pulse, 1);
        tick(); #1;
        check("ebreak_pulse_end", halt_pulse, 0);
        mem[4] = 32'h0000_0013;

        // Breakpoint at 0x008, resume executes it once
        clr = 1'b1; tick();
        pc = 32'd0; instr = mem[0]; bp_en = 1'b1; bp_addr = 32'h8;
        start = 1'b1; tick();
        for (int i = 0; i < 20 && pc != 32'h8; i++) tick();
        #1;
        check("bkpt_blocked", cpu_en, 0);
        tick(); #1;
        check("bkpt_cause", halt_cause, 4);
        check("bkpt_cnt", cycle_cnt, 2);
        start = 1'b1; tick(); #1;
        check("bkpt_resume_en", cpu_en, 1);
        check("bkpt_resume_cause", halt_cause, 0);
        tick(); #1;
        check("bkpt_continue_pc", pc, 32'hC);
        check("bkpt_continue_cnt", cycle_cnt, 3);
        check("bkpt_continue_en", cpu_en, 1);

        // External halt request
        halt_req = 1'b1; #1;
        check("req_blocked", cpu_en, 0);
        tick(); #1;
        check("req_cause", halt_cause, 1);
        check("req_cnt", cycle_cnt, 3);

        // Three single steps
        bp_en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1; tick(); #1;
            check("step_state", state, 2);
            check("step_en", cpu_en, 1);
            tick(); #1;
            check("step_cause", halt_cause, 6);
            check("step_cnt", cycle_cnt, 3 + k);
            check("step_en_off", cpu_en, 0);
        end

        // ILLEGAL outranks REQ
        start = 1'b1; tick();
        mem[pc[9:2]] = 32'd0; instr = 32'd0; halt_req = 1'b1; #1;
        check("illegal_blocked", cpu_en, 0);
        tick(); #1;
        check("illegal_cause", halt_cause, 3);
        start = 1'b1; tick(); #1;
        check("illegal_sticky", state, 3);
        mem[pc[9:2]] = 32'h0000_0013; instr = mem[pc[9:2]];

        // clr beats start mid-run; then start+step together picks RUN
        clr = 1'b1; tick();
        start = 1'b1; tick();
        tick(); tick(); tick(); #1;
        check("clr_pre_cnt", cycle_cnt, 3);
        clr = 1'b1; start = 1'b1; tick(); #1;
        check("clr_state", state, 0);
        check("clr_en", cpu_en, 0);
        check("clr_cnt", cycle_cnt, 0);
        check("clr_cause", halt_cause, 0);
        start = 1'b1; step = 1'b1; tick(); #1;
        check("both_state", state, 1);
        check("both_en", cpu_en, 1);

        // Reset mid-run: enable holds until the edge
        tick();
        rstn = 1'b0; #1;
        check("rst_mid_pre_en", cpu_en, 1);
        tick(); #1;
        check("rst_mid_state", state, 0);
        check("rst_mid_en", cpu_en, 0);
        check("rst_mid_cnt", cycle_cnt, 0);
        rstn = 1'b1;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
